// File: rtl/char_mem_pkg.sv
// char_mem_pkg: shared FSM state type and default video phase slots for char_mem_arbiter
package char_mem_pkg;
    typedef enum logic [1:0] {IDLE, PEND, DATA} state_t;
    localparam logic [2:0] CHAR_PHASE_DEF = 3'd0;
    localparam logic [2:0] FONT_PHASE_DEF = 3'd1;
endpackage

// File: rtl/char_mem_arbiter.sv
// char_mem_arbiter: shares one single-port character/font BRAM between video fetches and a CPU port
// Ports: clk, reset (sync, active high); phase/video_active/char_addr/font_addr from the video side;
// cpu_addr/cpu_rstrb/cpu_wstrb/cpu_wdata in, cpu_rbusy/cpu_wbusy/cpu_rdata out for the CPU;
// mem_addr/mem_we/mem_wdata out and mem_rdata in (1-cycle read latency) toward the BRAM.
// Optional: define CHAR_ARB_BLANK_BURST_EN to let the CPU use the video slots while video_active is low.
module char_mem_arbiter
    import char_mem_pkg::*;
#(
    parameter int         ADDR_W     = 13,
    parameter logic [2:0] CHAR_PHASE = CHAR_PHASE_DEF,
    parameter logic [2:0] FONT_PHASE = FONT_PHASE_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        phase,
    input  logic              video_active,
    input  logic [ADDR_W-1:0] char_addr,
    input  logic [ADDR_W-1:0] font_addr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_rstrb,
    input  logic              cpu_wstrb,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_rbusy,
    output logic              cpu_wbusy,
    output logic [31:0]       cpu_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);
    state_t            state, state_nxt;
    logic [ADDR_W-1:0] lat_addr;
    logic [7:0]        lat_wdata, rdata_q;
    logic              lat_write, video_slot, reserved, grant, strobe;

    assign video_slot = (phase == CHAR_PHASE) || (phase == FONT_PHASE);
`ifdef CHAR_ARB_BLANK_BURST_EN
    assign reserved = video_slot && video_active;
`else
    logic unused_video_active;
    assign unused_video_active = video_active;
    assign reserved = video_slot;
`endif
    assign strobe = cpu_rstrb || cpu_wstrb;
    assign grant  = (state == PEND) && !reserved;
    // a grant can only land on a video slot when that slot is released, so it takes the bus first
    assign mem_addr  = grant ? lat_addr : (phase == CHAR_PHASE) ? char_addr : font_addr;
    assign mem_we    = grant && lat_write && !reset;
    assign mem_wdata = lat_wdata;
    assign cpu_rdata = {4{rdata_q}};

    always_comb begin
        state_nxt = state;
        state_nxt = (state == IDLE) ? (strobe ? PEND : IDLE) :
                    (state == PEND) ? (grant ? (lat_write ? IDLE : DATA) : PEND) : IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_write <= 1'b0;
            rdata_q   <= '0;
            cpu_rbusy <= 1'b0;
            cpu_wbusy <= 1'b0;
        end else begin
            state <= state_nxt;
            // strobes are only taken in IDLE; a write wins over a simultaneous read
            if (state == IDLE && strobe) begin
                lat_addr  <= cpu_addr;
                lat_wdata <= cpu_wdata;
                lat_write <= cpu_wstrb;
                cpu_wbusy <= cpu_wstrb;
                cpu_rbusy <= !cpu_wstrb;
            end
            if (grant && lat_write) cpu_wbusy <= 1'b0;
            if (state == DATA) begin
                rdata_q   <= mem_rdata;
                cpu_rbusy <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_char_mem_arbiter.sv
// tb_char_mem_arbiter: table-driven and randomized self-checking bench for char_mem_arbiter
module tb_char_mem_arbiter;
`ifdef CHAR_ARB_BLANK_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif
    localparam logic [12:0] CHAR_A = 13'h1FFE;
    localparam logic [12:0] FONT_A = 13'h1FFF;

    logic        clk = 1'b0, reset = 1'b1, video_active = 1'b1;
    logic [2:0]  phase = 3'd0;
    logic [12:0] cpu_addr = '0, mem_addr;
    logic        cpu_rstrb = 1'b0, cpu_wstrb = 1'b0, cpu_rbusy, cpu_wbusy, mem_we;
    logic [7:0]  cpu_wdata = '0, mem_wdata, mem_rdata;
    logic [31:0] cpu_rdata;
    logic [7:0]  ram [0:8191];
    logic [7:0]  shadow [0:8191];
    int          checks = 0, errors = 0;

    char_mem_arbiter dut (
        .clk(clk), .reset(reset), .phase(phase), .video_active(video_active),
        .char_addr(CHAR_A), .font_addr(FONT_A), .cpu_addr(cpu_addr), .cpu_rstrb(cpu_rstrb),
        .cpu_wstrb(cpu_wstrb), .cpu_wdata(cpu_wdata), .cpu_rbusy(cpu_rbusy), .cpu_wbusy(cpu_wbusy),
        .cpu_rdata(cpu_rdata), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    function automatic bit slot_reserved(input logic [2:0] p, input bit va);
        return (p <= 3'd1) && (!BURST || va);
    endfunction

    // first cycle after the strobe whose phase the CPU may use
    function automatic int model_grant(input logic [2:0] p, input bit va);
        for (int k = 1; k <= 8; k++) begin
            logic [2:0] ph;
            ph = p + 3'(k);
            if (!slot_reserved(ph, va)) return k;
        end
        return -1;
    endfunction

    always @(negedge clk)
        if (mem_we) check("we_slot", {31'd0, reset || slot_reserved(phase, video_active)}, 32'd0);

    task automatic tick();
        @(posedge clk);
        #1;
        phase = phase + 3'd1;
    endtask

    task automatic run_op(input bit wr, input bit rd, input logic [12:0] a, input logic [7:0] d,
                          input logic [2:0] p, input bit va, input int g_exp, input int b_exp,
                          input logic [7:0] r_exp, input bit second);
        int g, b, acc, wes;
        bit shape_ok, other_ok, wd_ok, bz;
        video_active = va;
        while (phase != p) tick();
        cpu_addr = a; cpu_wdata = d; cpu_wstrb = wr; cpu_rstrb = rd;
        g = -1; b = -1; acc = 0; wes = 0; shape_ok = 1; other_ok = 1; wd_ok = 1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            cpu_wstrb = second && k == 1;
            cpu_rstrb = second && k == 1;
            if (second && k == 1) begin cpu_addr = a + 13'd1; cpu_wdata = ~d; end
            #1;
            if (mem_addr == a) begin acc++; if (g < 0) g = k; end
            if (mem_we) begin wes++; if (mem_wdata != d) wd_ok = 0; end
            bz = wr ? cpu_wbusy : cpu_rbusy;
            if (bz != (k < b_exp)) shape_ok = 0;
            if ((wr ? cpu_rbusy : cpu_wbusy) != 1'b0) other_ok = 0;
            if (b < 0 && !bz) b = k;
        end
        check("grant_cycle", g, g_exp);
        check("busy_low_cycle", b, b_exp);
        check("access_count", acc, 1);
        check("we_count", wes, {31'd0, wr});
        check("busy_shape", {31'd0, shape_ok}, 1);
        check("other_busy_low", {31'd0, other_ok}, 1);
        if (wr) begin
            check("wdata", {31'd0, wd_ok}, 1);
            shadow[a] = d;
        end else check("rdata", cpu_rdata, {4{r_exp}});
    endtask

    typedef struct {
        bit wr, rd;
        logic [12:0] a;
        logic [7:0] d;
        logic [2:0] p;
        bit va;
        int g, b;
        logic [7:0] r;
        bit second;
    } vec_t;
    vec_t tbl[12];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 8192; i++) begin ram[i] <= 8'h00; shadow[i] = 8'h00; end
        #1;
        ram[13'h010] <= 8'h41; shadow[13'h010] = 8'h41;
        tbl[0]  = '{1'b0, 1'b1, 13'h010, 8'h00, 3'd2, 1'b1, 1, 3, 8'h41, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 13'h020, 8'h5A, 3'd7, 1'b1, 3, 4, 8'h00, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 13'h020, 8'h00, 3'd3, 1'b1, 1, 3, 8'h5A, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 13'h030, 8'h77, 3'd4, 1'b1, 1, 2, 8'h00, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 13'h030, 8'h00, 3'd5, 1'b1, 1, 3, 8'h77, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 13'h040, 8'hC3, 3'd0, 1'b1, 2, 3, 8'h00, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 13'h040, 8'h00, 3'd1, 1'b1, 1, 3, 8'hC3, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 13'h010, 8'h00, 3'd7, 1'b0, BURST ? 1 : 3, BURST ? 3 : 5, 8'h41, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 13'h050, 8'h99, 3'd6, 1'b0, 1, 2, 8'h00, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 13'h060, 8'h11, 3'd7, 1'b1, 3, 4, 8'h00, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 13'h061, 8'h00, 3'd2, 1'b1, 1, 3, 8'h00, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 13'h060, 8'h00, 3'd6, 1'b1, 1, 3, 8'h11, 1'b0};
        repeat (3) tick();
        #1;
        check("reset_rbusy", {31'd0, cpu_rbusy}, 0);
        check("reset_wbusy", {31'd0, cpu_wbusy}, 0);
        check("reset_rdata", cpu_rdata, 0);
        check("reset_we", {31'd0, mem_we}, 0);
        reset = 1'b0; cpu_addr = 13'h010; cpu_rstrb = 1'b1;
        tick();
        cpu_rstrb = 1'b0;
        #1;
        check("post_reset_accept", {31'd0, cpu_rbusy}, 1);
        repeat (8) tick();
        check("post_reset_rdata", cpu_rdata, 32'h41414141);
        foreach (tbl[i])
            run_op(tbl[i].wr, tbl[i].rd, tbl[i].a, tbl[i].d, tbl[i].p, tbl[i].va,
                   tbl[i].g, tbl[i].g + (tbl[i].wr ? 1 : 2), tbl[i].r, tbl[i].second);
        for (int i = 0; i < 40; i++) begin
            bit wr, rd, va;
            logic [12:0] a;
            logic [7:0] d;
            logic [2:0] p;
            int g;
            wr = 1'($urandom); rd = 1'($urandom) || !wr; va = 1'($urandom);
            a = 13'($urandom_range(256, 287)); d = 8'($urandom); p = 3'($urandom);
            g = model_grant(p, va);
            run_op(wr, rd, a, d, p, va, g, g + (wr ? 1 : 2), shadow[a], 1'b0);
        end
        video_active = 1'b1;
        while (phase != 3'd2) tick();
        cpu_addr = 13'h020; cpu_rstrb = 1'b1;
        tick();
        cpu_rstrb = 1'b0;
        tick();
        #1;
        check("data_rbusy", {31'd0, cpu_rbusy}, 1);
        reset = 1'b1;
        tick();
        #1;
        check("rst_data_rbusy", {31'd0, cpu_rbusy}, 0);
        check("rst_data_rdata", cpu_rdata, 0);
        reset = 1'b0;
        while (phase != 3'd7) tick();
        cpu_addr = 13'h070; cpu_wdata = 8'hEE; cpu_wstrb = 1'b1;
        tick();
        cpu_wstrb = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("rst_grant_we", {31'd0, mem_we}, 0);
        tick();
        reset = 1'b0;
        run_op(1'b0, 1'b1, 13'h070, 8'h00, 3'd3, 1'b1, 1, 3, shadow[13'h070], 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
